// File: rtl/pcie_bridge_arbiter.sv
// Round-robin arbiter for the PCIe bridge register write port; accept to rsp_valid is 3 cycles (2 without readback).
// Requests stall by holding req_valid; req_ready pulses only in IDLE, and the FSM is never stalled once a request is taken.
module pcie_bridge_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      br_we,
  output logic [DATA_W-1:0]         br_wdata,
  input  logic [DATA_W-1:0]         br_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, RESP} state_t;

  state_t            state;
  logic [IW-1:0]     last;
  logic [IW-1:0]     gid;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     idx;
  logic              any;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] rdreg;
  logic              err;

  // Search starts just after the previous winner, so the winner drops to lowest priority.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

  // Gated by rst_n so nothing appears accepted while the state is held in reset.
  assign req_ready = (state == IDLE && any && rst_n) ? (NUM_REQ'(1) << pick) : '0;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << gid) : '0;
  assign rsp_err   = (state == RESP) && err;
  assign rsp_rdata = rdreg;
  assign busy      = (state != IDLE);
  assign br_we     = (state == WRITE);
  assign br_wdata  = hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= IW'(NUM_REQ - 1);
      gid   <= '0;
      hold  <= '0;
      rdreg <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            hold  <= req_wdata[int'(pick)*DATA_W +: DATA_W];
            gid   <= pick;
            last  <= pick;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (VERIFY_EN) begin
            state <= VERIFY;
          end else begin
            // rdreg only changes on the way into RESP, so rsp_rdata holds between responses.
            rdreg <= hold;
            err   <= 1'b0;
            state <= RESP;
          end
        end
        VERIFY: begin
          rdreg <= br_rdata;
          err   <= (br_rdata != hold);
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
